// File: rtl/data_sram_responder.sv
// Data-SRAM responder: word-addressed RAM plus MMIO window (LED, switches, NUM, TIMER).
// Optional unmapped-access error log enabled by defining DSRAM_ERR_LOG_EN.
module data_sram_responder #(
    parameter int unsigned RAM_AW    = 12,
    parameter logic [15:0] MMIO_BASE = 16'hbfaf
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [3:0]  wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [15:0] switch_in,
    output logic [15:0] led_out,
    output logic [31:0] num_out
);

    localparam logic [15:0] OFF_LED   = 16'hf000;
    localparam logic [15:0] OFF_SW    = 16'hf004;
    localparam logic [15:0] OFF_NUM   = 16'hf010;
    localparam logic [15:0] OFF_TIMER = 16'he000;
`ifdef DSRAM_ERR_LOG_EN
    localparam logic [15:0] OFF_ERRA  = 16'hf020;
    localparam logic [15:0] OFF_ERRV  = 16'hf024;
`endif

    logic [31:0] mem [2**RAM_AW];

    logic [31:0] rdata_q, rdata_d;
    logic [15:0] led_q, led_d;
    logic [31:0] num_q, num_d;
    logic [31:0] timer_q, timer_d;

    logic              mmio_sel;
    logic [15:0]       off;
    logic [RAM_AW-1:0] ram_idx;
    logic              rd_req;
    logic              wr_req;
    logic [31:0]       rd_val;
    logic [31:0]       led_merged;
    logic              mapped;

    logic unused_addr_lsb;
    assign unused_addr_lsb = &{1'b0, addr[1:0]};

    assign mmio_sel = (addr[31:16] == MMIO_BASE);
    assign off      = addr[15:0];
    assign ram_idx  = addr[RAM_AW+1:2];
    assign rd_req   = en && (wen == 4'h0);
    assign wr_req   = en && (wen != 4'h0);

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

`ifdef DSRAM_ERR_LOG_EN
    logic [31:0] err_addr_q, err_addr_d;
    logic        err_vld_q, err_vld_d;
`endif

    always_comb begin
        rdata_d    = rdata_q;
        led_d      = led_q;
        num_d      = num_q;
        timer_d    = timer_q + 32'd1;
        rd_val     = '0;
        led_merged = '0;
        mapped     = 1'b0;
`ifdef DSRAM_ERR_LOG_EN
        err_addr_d = err_addr_q;
        err_vld_d  = err_vld_q;
`endif

        if (mmio_sel) begin
            unique case (off)
                OFF_LED:   begin rd_val = {16'h0, led_q};     mapped = 1'b1; end
                OFF_SW:    begin rd_val = {16'h0, switch_in}; mapped = 1'b1; end
                OFF_NUM:   begin rd_val = num_q;              mapped = 1'b1; end
                OFF_TIMER: begin rd_val = timer_q;            mapped = 1'b1; end
`ifdef DSRAM_ERR_LOG_EN
                OFF_ERRA:  begin rd_val = err_addr_q;         mapped = 1'b1; end
                OFF_ERRV:  begin rd_val = {31'h0, err_vld_q}; mapped = 1'b1; end
`endif
                default:   begin rd_val = '0;                 mapped = 1'b0; end
            endcase
        end else begin
            rd_val = mem[ram_idx];
        end

        if (rd_req) rdata_d = rd_val;

        if (wr_req && mmio_sel) begin
            // LED only has lanes 0/1; upper enables are masked off
            led_merged = lane_merge({16'h0, led_q}, wdata, {2'b00, wen[1:0]});
            case (off)
                OFF_LED:   led_d   = led_merged[15:0];
                OFF_NUM:   num_d   = lane_merge(num_q, wdata, wen);
                OFF_TIMER: timer_d = lane_merge(timer_q, wdata, wen);
`ifdef DSRAM_ERR_LOG_EN
                OFF_ERRV:  err_vld_d = 1'b0;
`endif
                default: ;
            endcase
        end

`ifdef DSRAM_ERR_LOG_EN
        if (en && mmio_sel && !mapped && !err_vld_q) begin
            err_addr_d = addr;
            err_vld_d  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
            led_q   <= '0;
            num_q   <= '0;
            timer_q <= '0;
        end else begin
            rdata_q <= rdata_d;
            led_q   <= led_d;
            num_q   <= num_d;
            timer_q <= timer_d;
        end
    end

`ifdef DSRAM_ERR_LOG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_addr_q <= '0;
            err_vld_q  <= 1'b0;
        end else begin
            err_addr_q <= err_addr_d;
            err_vld_q  <= err_vld_d;
        end
    end
`endif

    // RAM contents are deliberately not reset; a request during reset is dropped
    always_ff @(posedge clk) begin
        if (!reset && wr_req && !mmio_sel) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wen[i]) mem[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata   = rdata_q;
    assign led_out = led_q;
    assign num_out = num_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: RAM lanes, MMIO registers, timer wrap, reset drop.
// Error-log checks are built when DSRAM_ERR_LOG_EN is defined.
module tb_data_sram_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [15:0] switch_in;
    logic [15:0] led_out;
    logic [31:0] num_out;

    int errors = 0;
    int checks = 0;

    data_sram_responder #(.RAM_AW(12), .MMIO_BASE(16'hbfaf)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .wen       (wen),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .switch_in (switch_in),
        .led_out   (led_out),
        .num_out   (num_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        en = 1'b1; wen = be; addr = a; wdata = d;
        step();
        en = 1'b0; wen = 4'h0;
    endtask

    task automatic rd(input logic [31:0] a);
        en = 1'b1; wen = 4'h0; addr = a; wdata = '0;
        step();
        en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; wen = 4'h0; addr = '0; wdata = '0; switch_in = 16'h0;
        step(); step(); step();
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_led", {16'h0, led_out}, 32'h0);
        chk("reset_num", num_out, 32'h0);

        reset = 1'b0;
        rd(32'hbfafe000);
        chk("timer_first", rdata, 32'h0);

        wr(32'h00000010, 32'h11223344, 4'hf);
        wr(32'h00000010, 32'haabbccdd, 4'b0101);
        rd(32'h00000010);
        chk("ram_lanes", rdata, 32'h11bb33dd);
        rd(32'h00004010);
        chk("ram_alias", rdata, 32'h11bb33dd);

        wr(32'hbfaff000, 32'hffff1234, 4'hf);
        chk("led_write", {16'h0, led_out}, 32'h00001234);
        wr(32'hbfaff000, 32'h0000ab00, 4'b0010);
        chk("led_lane1", {16'h0, led_out}, 32'h0000ab34);
        switch_in = 16'h00a5;
        wr(32'hbfaff004, 32'hffffffff, 4'hf);
        rd(32'hbfaff004);
        chk("switch_rd", rdata, 32'h000000a5);

        wr(32'hbfaff010, 32'hdeadbeef, 4'hf);
        chk("num_write", num_out, 32'hdeadbeef);
        wr(32'hbfaff010, 32'h00005500, 4'b0010);
        chk("num_lane1", num_out, 32'hdead55ef);
        chk("rdata_hold_wr", rdata, 32'h000000a5);
        step();
        chk("rdata_hold_idle", rdata, 32'h000000a5);
        rd(32'hbfaff010);
        chk("num_rd", rdata, 32'hdead55ef);

        wr(32'hbfafe000, 32'hfffffffe, 4'hf);
        step();
        rd(32'hbfafe000);
        chk("timer_max", rdata, 32'hffffffff);
        rd(32'hbfafe000);
        chk("timer_wrap", rdata, 32'h0);
        rd(32'hbfafe000);
        chk("timer_inc", rdata, 32'h1);
        wr(32'hbfafe000, 32'h000000ff, 4'b0001);
        rd(32'hbfafe000);
        chk("timer_lane0", rdata, 32'h000000ff);

        rd(32'hbfaf0000);
        chk("unmapped_rd", rdata, 32'h0);
`ifdef DSRAM_ERR_LOG_EN
        rd(32'hbfaff020);
        chk("err_addr", rdata, 32'hbfaf0000);
        rd(32'hbfaff024);
        chk("err_vld", rdata, 32'h1);
        rd(32'hbfaf0004);
        rd(32'hbfaff020);
        chk("err_addr_kept", rdata, 32'hbfaf0000);
        wr(32'hbfaff024, 32'h0, 4'hf);
        rd(32'hbfaff024);
        chk("err_vld_clr", rdata, 32'h0);
`else
        rd(32'hbfaff000);
        chk("led_rd", rdata, 32'h0000ab34);
        rd(32'hbfaff020);
        chk("f020_unmapped", rdata, 32'h0);
`endif

        wr(32'h00000020, 32'h5a5a5a5a, 4'hf);
        en = 1'b1; addr = 32'h00000010;
        step();
        chk("b2b_rd0", rdata, 32'h11bb33dd);
        addr = 32'h00000020;
        step();
        chk("b2b_rd1", rdata, 32'h5a5a5a5a);

        reset = 1'b1; en = 1'b1; wen = 4'hf; addr = 32'h00000020; wdata = 32'h0;
        step();
        chk("reset_req_rdata", rdata, 32'h0);
        chk("reset_req_led", {16'h0, led_out}, 32'h0);
        reset = 1'b0; wen = 4'h0;
        rd(32'h00000020);
        chk("ram_kept", rdata, 32'h5a5a5a5a);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
